// File: rtl/d8_led_ctrl.sv
// d8 register-mapped LED controller: per-channel off/on/blink/PWM modes
// driven from one shared, free-running prescaled timebase.
module d8_led_ctrl #(
    parameter int N_CH  = 8,
    parameter int PWM_W = 8,
    parameter int PRESC = 4
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    input  logic            we,
    input  logic            re,
    input  logic [7:0]      addr,
    input  logic [7:0]      wdata,
    output logic [7:0]      rdata,
    output logic [N_CH-1:0] leds
);

    localparam int PCW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PCW-1:0] PRESC_MAX = PCW'(PRESC - 1);
    localparam logic [8:0] NREG = 9'(2 * N_CH);

    typedef enum logic [1:0] {
        M_OFF   = 2'd0,
        M_ON    = 2'd1,
        M_BLINK = 2'd2,
        M_PWM   = 2'd3
    } mode_e;

    logic [1:0]       mode_q [N_CH];
    logic [PWM_W-1:0] duty_q [N_CH];

    logic [PCW-1:0]   presc_cnt_q, presc_cnt_d;
    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic             blink_q, blink_d;
    logic [7:0]       rdata_q, rdata_d;
    logic [N_CH-1:0]  leds_q, leds_d;

    logic             tick;
    logic             wrap;
    logic             in_range;
    logic [6:0]       sel_ch;

    assign in_range = ({1'b0, addr} < NREG);
    assign sel_ch   = addr[7:1];
    assign tick     = (presc_cnt_q == PRESC_MAX);
    assign wrap     = tick && (pwm_cnt_q == {PWM_W{1'b1}});

    // Next timebase state: prescaler, PWM counter, blink phase.
    always_comb begin
        presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
        pwm_cnt_d   = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
        blink_d     = wrap ? ~blink_q : blink_q;
    end

    // Register read mux; unmapped addresses read as zero.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = 8'h00;
            for (int ch = 0; ch < N_CH; ch++) begin
                if (in_range && sel_ch == 7'(ch)) begin
                    if (addr[0]) begin
                        rdata_d = 8'(duty_q[ch]);
                    end else begin
                        rdata_d = {6'b0, mode_q[ch]};
                    end
                end
            end
        end
    end

    // Per-channel LED level from current mode/duty and timebase.
    always_comb begin
        leds_d = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            case (mode_e'(mode_q[ch]))
                M_OFF:   leds_d[ch] = 1'b0;
                M_ON:    leds_d[ch] = 1'b1;
                M_BLINK: leds_d[ch] = blink_q;
                M_PWM:   leds_d[ch] = (pwm_cnt_q < duty_q[ch]);
                default: leds_d[ch] = 1'b0;
            endcase
        end
    end

    // Mode/duty register file; out-of-range writes fall through.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                mode_q[ch] <= '0;
                duty_q[ch] <= '0;
            end
        end else if (we && in_range) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                if (sel_ch == 7'(ch)) begin
                    if (addr[0]) begin
                        duty_q[ch] <= wdata[PWM_W-1:0];
                    end else begin
                        mode_q[ch] <= wdata[1:0];
                    end
                end
            end
        end
    end

    // Timebase, read data and LED outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            presc_cnt_q <= '0;
            pwm_cnt_q   <= '0;
            blink_q     <= 1'b0;
            rdata_q     <= 8'h00;
            leds_q      <= '0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            blink_q     <= blink_d;
            rdata_q     <= rdata_d;
            leds_q      <= leds_d;
        end
    end

    assign rdata = rdata_q;
    assign leds  = leds_q;

endmodule

// File: tb/tb_d8_led_ctrl.sv
// Scoreboard bench for d8_led_ctrl: a time-based reference model feeds
// expected leds/rdata into a queue; a monitor pops and compares each cycle.
module tb_d8_led_ctrl;

    localparam int N = 8;
    localparam int W = 8;
    localparam int P = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         we = 1'b0;
    logic         re = 1'b0;
    logic [7:0]   addr = 8'h00;
    logic [7:0]   wdata = 8'h00;
    logic [7:0]   rdata;
    logic [N-1:0] leds;

    d8_led_ctrl #(.N_CH(N), .PWM_W(W), .PRESC(P)) dut (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .we       (we),
        .re       (re),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .leds     (leds)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] leds;
        logic [7:0]   rdata;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    // reference model state
    int           mode_m[N];
    int           duty_m[N];
    longint       t_m;
    logic [7:0]   rdata_m;
    logic         rst_drv;

    function automatic logic [7:0] rd_model(input logic [7:0] a);
        int i;
        if (int'(a) >= 2 * N) return 8'h00;
        i = int'(a) / 2;
        if (a[0]) return 8'(duty_m[i]);
        return 8'(mode_m[i]);
    endfunction

    function automatic logic [N-1:0] leds_model();
        logic [N-1:0] r;
        longint pwm;
        longint blink;
        pwm   = (t_m / P) % (longint'(1) << W);
        blink = (t_m / (P * (longint'(1) << W))) % 2;
        r = '0;
        for (int c = 0; c < N; c++) begin
            case (mode_m[c])
                1: r[c] = 1'b1;
                2: r[c] = (blink == 1);
                3: r[c] = (pwm < longint'(duty_m[c]));
                default: r[c] = 1'b0;
            endcase
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            mode_m[c] = 0;
            duty_m[c] = 0;
        end
        t_m = 0;
        rdata_m = 8'h00;
    endtask

    // advance the model across the coming rising edge and push its outcome
    task automatic model_edge();
        exp_t e;
        if (!rst_n) begin
            model_reset();
            e.leds = '0;
            e.rdata = 8'h00;
        end else begin
            e.leds = leds_model();
            if (re) rdata_m = rd_model(addr);
            e.rdata = rdata_m;
            if (we && int'(addr) < 2 * N) begin
                if (addr[0]) duty_m[int'(addr) / 2] = int'(wdata) % (1 << W);
                else         mode_m[int'(addr) / 2] = int'(wdata) % 4;
            end
            t_m++;
        end
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic w, input logic r,
                       input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        rst_n = rst_drv;
        we = w;
        re = r;
        addr = a;
        wdata = d;
        model_edge();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // count cycles leds[ch] is high over n cycles, sampled mid-low phase
    task automatic count_high(input int ch, input int n, output int hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b0, 8'h00, 8'h00);
            if (leds[ch]) hi++;
        end
    endtask

    // monitor: compare DUT outputs against the scoreboard after each edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("leds", 64'(leds), 64'(e.leds));
                check("rdata", 64'(rdata), 64'(e.rdata));
            end
        end
    end

    initial begin
        int hi;
        model_reset();
        rst_drv = 1'b0;

        // reset held with bus activity
        for (int i = 0; i < 8; i++)
            cyc(1'($urandom), 1'($urandom), 8'($urandom % 16), 8'($urandom));

        // release; confirm no register changed
        rst_drv = 1'b1;
        for (int a = 0; a < 2 * N; a++) cyc(1'b0, 1'b1, 8'(a), 8'h00);

        // static on
        cyc(1'b1, 1'b0, 8'd0, 8'h01);
        cyc(1'b1, 1'b0, 8'd14, 8'h01);
        cyc(1'b0, 1'b1, 8'd0, 8'h00);
        idle(3);

        // PWM duty 64 then 0
        cyc(1'b1, 1'b0, 8'd7, 8'd64);
        cyc(1'b1, 1'b0, 8'd6, 8'd3);
        idle(2);
        count_high(3, 1024, hi);
        check("pwm_duty64_high", 64'(hi), 64'd256);
        cyc(1'b1, 1'b0, 8'd7, 8'd0);
        idle(2);
        count_high(3, 1024, hi);
        check("pwm_duty0_high", 64'(hi), 64'd0);

        // blink over more than a full period
        cyc(1'b1, 1'b0, 8'd2, 8'd2);
        idle(2100);

        // bounds and masking
        cyc(1'b1, 1'b0, 8'(2 * N), 8'hFF);
        cyc(1'b1, 1'b0, 8'hFF, 8'hFF);
        cyc(1'b0, 1'b1, 8'(2 * N), 8'h00);
        cyc(1'b0, 1'b1, 8'hFF, 8'h00);
        cyc(1'b1, 1'b0, 8'd4, 8'hFF);
        cyc(1'b0, 1'b1, 8'd4, 8'h00);
        for (int a = 0; a < 2 * N; a++) cyc(1'b0, 1'b1, 8'(a), 8'h00);

        // simultaneous write and read of the same register
        cyc(1'b1, 1'b0, 8'd5, 8'hA5);
        cyc(1'b1, 1'b1, 8'd5, 8'h3C);
        cyc(1'b0, 1'b1, 8'd5, 8'h00);
        idle(1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] a;
            a = ($urandom % 8 == 0) ? 8'($urandom) : 8'($urandom % (2 * N));
            cyc(1'($urandom % 4 == 0), 1'($urandom % 3 == 0), a, 8'($urandom));
        end

        // asynchronous reset in the middle of a PWM period
        cyc(1'b1, 1'b0, 8'd7, 8'd200);
        cyc(1'b1, 1'b0, 8'd6, 8'd3);
        idle(300);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        rst_drv = 1'b0;
        #1;
        check("async_rst_leds", 64'(leds), 64'd0);
        check("async_rst_rdata", 64'(rdata), 64'd0);
        idle(4);
        rst_drv = 1'b1;
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom % 4 == 0), 1'($urandom % 3 == 0),
                8'($urandom % (2 * N + 2)), 8'($urandom));
        end
        idle(2);

        // drain, bounded
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
